hwag_crank_gen: RTL and testbench

//  Synthetic crank trigger-wheel generator: the encoder counterpart of the HWAG decoder chain.

---
 rtl/hwag_crank_gen_pkg.sv | 16 +
 rtl/hwag_crank_gen_if.sv | 25 ++
 rtl/hwag_crank_gen_period_ctr.sv | 65 ++++++
 rtl/hwag_crank_gen.sv | 106 ++++++++++
 tb/tb_hwag_crank_gen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hwag_crank_gen_pkg.sv
// Shared HWAG constants and state encoding for the synthetic crank-wheel generator.
// Tooth geometry matches the hwag decoder (decoder tcnt top 57 = TEETH-MISSING-1).
package hwag_crank_gen_pkg;

    localparam int PCNT_WIDTH = 24;
    localparam int TCNT_WIDTH = 8;
    localparam int TEETH      = 60;
    localparam int MISSING    = 2;
    localparam int MIN_PERIOD = 4;

    typedef enum logic [0:0] {
        CG_IDLE = 1'b0,
        CG_RUN  = 1'b1
    } crank_gen_state_t;

endpackage

// File: rtl/hwag_crank_gen_if.sv
// Control and wheel-output bundle of the crank generator.
// The master modport is the controlling side; the slave modport is the generator.
interface hwag_crank_gen_if import hwag_crank_gen_pkg::*; ();

    logic                  ena;
    logic [PCNT_WIDTH-1:0] period;
    logic                  period_wr;
    logic                  crank_out;
    logic [TCNT_WIDTH-1:0] tooth_num;
    logic                  tooth_stb;
    logic                  rev_stb;
    logic                  busy;
    logic                  period_err;

    modport master (
        output ena, period, period_wr,
        input  crank_out, tooth_num, tooth_stb, rev_stb, busy, period_err
    );

    modport slave (
        input  ena, period, period_wr,
        output crank_out, tooth_num, tooth_stb, rev_stb, busy, period_err
    );

endinterface

// File: rtl/hwag_crank_gen_period_ctr.sv
// Tooth-period bookkeeping: clamped shadow register, per-tooth active period,
// in-tooth cycle counter and tooth-boundary detection.
module hwag_crank_gen_period_ctr import hwag_crank_gen_pkg::*; #(
    parameter int MIN_PERIOD = hwag_crank_gen_pkg::MIN_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PCNT_WIDTH-1:0] period,
    input  logic                  period_wr,
    input  logic                  start,
    input  logic                  run,
    output logic [PCNT_WIDTH-1:0] pcnt_next,
    output logic [PCNT_WIDTH-1:0] active_next,
    output logic                  boundary,
    output logic                  period_err
);

    localparam logic [PCNT_WIDTH-1:0] MIN_P = PCNT_WIDTH'(MIN_PERIOD);

    logic [PCNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [PCNT_WIDTH-1:0] active_q, active_d;
    logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                  period_err_q, period_err_d;
    logic                  load;

    function automatic logic [PCNT_WIDTH-1:0] clamp_period(input logic [PCNT_WIDTH-1:0] p);
        return (p < MIN_P) ? MIN_P : p;
    endfunction

    always_comb begin
        // shadow_d already carries a same-edge write, so a write on a boundary
        // lands in the tooth that is just starting
        shadow_d     = period_wr ? clamp_period(period) : shadow_q;
        period_err_d = period_wr ? (period < MIN_P) : period_err_q;
        boundary     = run && (pcnt_q == (active_q - PCNT_WIDTH'(1)));
        load         = start || boundary;
        active_d     = load ? shadow_d : active_q;
        if (load) begin
            pcnt_d = '0;
        end else if (run) begin
            pcnt_d = pcnt_q + PCNT_WIDTH'(1);
        end else begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= MIN_P;
            active_q     <= MIN_P;
            pcnt_q       <= '0;
            period_err_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pcnt_q       <= pcnt_d;
            period_err_q <= period_err_d;
        end
    end

    assign pcnt_next   = pcnt_d;
    assign active_next = active_d;
    assign period_err  = period_err_q;

endmodule

// File: rtl/hwag_crank_gen.sv
// Synthetic 60-2 style crank trigger-wheel generator: run/stop FSM, tooth counter
// and registered wheel outputs aligned with the in-tooth cycle counter.
module hwag_crank_gen import hwag_crank_gen_pkg::*; #(
    parameter int TEETH      = hwag_crank_gen_pkg::TEETH,
    parameter int MISSING    = hwag_crank_gen_pkg::MISSING,
    parameter int MIN_PERIOD = hwag_crank_gen_pkg::MIN_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    hwag_crank_gen_if.slave  bus
);

    localparam logic [TCNT_WIDTH-1:0] TOOTH_LAST    = TCNT_WIDTH'(TEETH - 1);
    localparam logic [TCNT_WIDTH-1:0] FIRST_MISSING = TCNT_WIDTH'(TEETH - MISSING);

    crank_gen_state_t      state_q, state_d;
    logic [TCNT_WIDTH-1:0] tooth_num_q, tooth_num_d;
    logic                  tooth_stb_q, tooth_stb_d;
    logic                  rev_stb_q, rev_stb_d;
    logic                  busy_q, busy_d;
    logic                  crank_out_q, crank_out_d;

    logic                  start;
    logic                  run;
    logic                  boundary;
    logic [PCNT_WIDTH-1:0] pcnt_next;
    logic [PCNT_WIDTH-1:0] active_next;
    logic                  period_err;

    assign start = (state_q == CG_IDLE) && bus.ena;
    assign run   = (state_q == CG_RUN);

    hwag_crank_gen_period_ctr #(
        .MIN_PERIOD (MIN_PERIOD)
    ) u_period_ctr (
        .clk         (clk),
        .rst         (rst),
        .period      (bus.period),
        .period_wr   (bus.period_wr),
        .start       (start),
        .run         (run),
        .pcnt_next   (pcnt_next),
        .active_next (active_next),
        .boundary    (boundary),
        .period_err  (period_err)
    );

    always_comb begin
        state_d     = state_q;
        tooth_num_d = tooth_num_q;
        tooth_stb_d = 1'b0;
        rev_stb_d   = 1'b0;
        unique case (state_q)
            CG_IDLE: begin
                if (bus.ena) begin
                    state_d     = CG_RUN;
                    tooth_num_d = '0;
                    tooth_stb_d = 1'b1;
                    rev_stb_d   = 1'b1;
                end
            end
            CG_RUN: begin
                if (boundary) begin
                    if (!bus.ena) begin
                        state_d     = CG_IDLE;
                        tooth_num_d = '0;
                    end else begin
                        tooth_num_d = (tooth_num_q == TOOTH_LAST) ? '0 : tooth_num_q + TCNT_WIDTH'(1);
                        tooth_stb_d = 1'b1;
                        rev_stb_d   = (tooth_num_d == '0);
                    end
                end
            end
            default: state_d = CG_IDLE;
        endcase
        busy_d = (state_d == CG_RUN);
        // Next-cycle values keep crank_out aligned with the counter it is derived from
        crank_out_d = busy_d && (tooth_num_d < FIRST_MISSING) && (pcnt_next < (active_next >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CG_IDLE;
            tooth_num_q <= '0;
            tooth_stb_q <= 1'b0;
            rev_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
            crank_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tooth_num_q <= tooth_num_d;
            tooth_stb_q <= tooth_stb_d;
            rev_stb_q   <= rev_stb_d;
            busy_q      <= busy_d;
            crank_out_q <= crank_out_d;
        end
    end

    assign bus.crank_out  = crank_out_q;
    assign bus.tooth_num  = tooth_num_q;
    assign bus.tooth_stb  = tooth_stb_q;
    assign bus.rev_stb    = rev_stb_q;
    assign bus.busy       = busy_q;
    assign bus.period_err = period_err;

endmodule

// File: tb/tb_hwag_crank_gen.sv
// Scoreboard bench for hwag_crank_gen: stimulus queues the expected shape of every
// tooth (index, rev flag, high cycles, length); a monitor measures and compares them.
module tb_hwag_crank_gen;
    import hwag_crank_gen_pkg::*;

    typedef struct {
        int num;
        bit rev;
        int high;
        int len;
    } tooth_t;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    tooth_t exp_q[$];
    tooth_t cur;
    bit     in_tooth = 1'b0;

    hwag_crank_gen_if bus ();

    hwag_crank_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int num, input bit rev, input int high, input int len);
        tooth_t t;
        t.num = num; t.rev = rev; t.high = high; t.len = len;
        exp_q.push_back(t);
    endtask

    task automatic wait_tooth(input int n);
        bit hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            tick();
            hit = bus.tooth_stb && (int'(bus.tooth_num) == n);
        end
        nvec++;
        if (!hit) begin
            nerr++;
            $display("FAIL wait_tooth%0d: no tooth_stb for tooth %0d within 1000 cycles", n, n);
        end
    endtask

    task automatic write_period(input int p);
        bus.period    = PCNT_WIDTH'(p);
        bus.period_wr = 1'b1;
        tick();
        bus.period_wr = 1'b0;
    endtask

    task automatic finish_tooth();
        tooth_t e;
        nvec++;
        if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL tooth_unexpected: got num=%0d rev=%0d high=%0d len=%0d, none expected",
                     cur.num, cur.rev, cur.high, cur.len);
        end else begin
            e = exp_q.pop_front();
            if (cur.num != e.num || cur.rev != e.rev || cur.high != e.high || cur.len != e.len) begin
                nerr++;
                $display("FAIL tooth%0d: got num=%0d rev=%0d high=%0d len=%0d expected num=%0d rev=%0d high=%0d len=%0d",
                         e.num, cur.num, cur.rev, cur.high, cur.len, e.num, e.rev, e.high, e.len);
            end
        end
    endtask

    // Monitor: measures each tooth from its tooth_stb to the next one or to busy dropping
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tooth_stb === 1'b1) begin
                if (in_tooth) finish_tooth();
                cur.num  = int'(bus.tooth_num);
                cur.rev  = bus.rev_stb;
                cur.high = int'(bus.crank_out);
                cur.len  = 1;
                in_tooth = 1'b1;
            end else if (in_tooth) begin
                if (bus.busy === 1'b1) begin
                    cur.len++;
                    cur.high += int'(bus.crank_out);
                end else begin
                    finish_tooth();
                    in_tooth = 1'b0;
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.ena       = 1'b0;
        bus.period    = '0;
        bus.period_wr = 1'b0;
        tick(3);
        check("rst_crank_out",  int'(bus.crank_out),  0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_tooth_num",  int'(bus.tooth_num),  0);
        check("rst_tooth_stb",  int'(bus.tooth_stb),  0);
        check("rst_rev_stb",    int'(bus.rev_stb),    0);
        check("rst_period_err", int'(bus.period_err), 0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", int'(bus.busy), 0);

        // Revolution 1 at P=8: 58 teeth 4/4, then two missing teeth
        write_period(8);
        check("p8_period_err", int'(bus.period_err), 0);
        for (int i = 0; i < 60; i++) push(i, i == 0, (i < 58) ? 4 : 0, 8);
        // Revolution 2: period changes mid-tooth take effect on the following tooth
        push(0, 1'b1, 3, 7);
        push(1, 1'b0, 3, 7);
        push(2, 1'b0, 2, 4);
        push(3, 1'b0, 5, 10);
        push(4, 1'b0, 4, 8);
        push(5, 1'b0, 8, 16);
        bus.ena = 1'b1;
        wait_tooth(59);
        tick(2);
        write_period(7);
        wait_tooth(1);
        tick(2);
        write_period(2);
        check("p2_period_err", int'(bus.period_err), 1);
        wait_tooth(2);
        tick(1);
        write_period(10);
        check("p10_period_err", int'(bus.period_err), 0);
        wait_tooth(3);
        tick(2);
        write_period(8);
        wait_tooth(4);
        tick(3);
        write_period(16);

        // Stop request at pcnt=2 of tooth 5: the tooth completes, then idle
        wait_tooth(5);
        tick(2);
        bus.ena = 1'b0;
        tick(13);
        check("stop_busy_before_boundary", int'(bus.busy), 1);
        tick(1);
        check("stop_busy",      int'(bus.busy),      0);
        check("stop_crank_out", int'(bus.crank_out), 0);
        check("stop_tooth_num", int'(bus.tooth_num), 0);
        check("stop_tooth_stb", int'(bus.tooth_stb), 0);

        // Restart at tooth 0; a write on the first boundary shapes tooth 1 already
        push(0, 1'b1, 8, 16);
        for (int i = 1; i < 30; i++) push(i, 1'b0, 3, 6);
        push(30, 1'b0, 2, 3);
        bus.ena = 1'b1;
        tick(1);
        check("restart_tooth_num", int'(bus.tooth_num), 0);
        check("restart_rev_stb",   int'(bus.rev_stb),   1);
        check("restart_tooth_stb", int'(bus.tooth_stb), 1);
        check("restart_crank_out", int'(bus.crank_out), 1);
        tick(15);
        write_period(6);
        wait_tooth(29);
        tick(2);
        write_period(3);
        check("p3_period_err", int'(bus.period_err), 1);

        // Reset at pcnt=2 of tooth 30 (P=4): the tooth is cut short
        wait_tooth(30);
        tick(2);
        rst     = 1'b1;
        bus.ena = 1'b0;
        tick(1);
        check("midrst_crank_out",  int'(bus.crank_out),  0);
        check("midrst_busy",       int'(bus.busy),       0);
        check("midrst_tooth_num",  int'(bus.tooth_num),  0);
        check("midrst_tooth_stb",  int'(bus.tooth_stb),  0);
        check("midrst_rev_stb",    int'(bus.rev_stb),    0);
        check("midrst_period_err", int'(bus.period_err), 0);
        rst = 1'b0;
        tick(4);
        check("post_rst_busy", int'(bus.busy), 0);
        check("scoreboard_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
